// File: rtl/layer_sequencer_if.sv
// Control bundle between the layer sequencer, its requester and the AG/ALU datapath.
// The slave side is the sequencer itself.
interface layer_sequencer_if #(
  parameter int IN_W   = 2,
  parameter int NEUR_W = 2
);
  logic              start;
  logic              busy;
  logic              done;
  logic              AG_rst;
  logic              AG_read;
  logic              ALU_rst;
  logic              ALU_en;
  logic              bias_sel;
  logic [IN_W-1:0]   in_idx;
  logic              out_we;
  logic [NEUR_W-1:0] out_addr;

  modport master (
    output start,
    input  busy, done,
    input  AG_rst, AG_read, in_idx,
    input  ALU_rst, ALU_en, bias_sel,
    input  out_we, out_addr
  );

  modport slave (
    input  start,
    output busy, done,
    output AG_rst, AG_read, in_idx,
    output ALU_rst, ALU_en, bias_sel,
    output out_we, out_addr
  );
endinterface

// File: rtl/layer_sequencer.sv
// Fully-connected layer sequencer: per-neuron clear/issue/drain/write with start/busy/done.
// Define LAYER_SEQ_BIAS_EN to add a bias MAC term after the last input of each neuron.
module layer_sequencer #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 3,
  parameter int MEM_LAT     = 1,
  parameter int IN_W   = (NUM_INPUTS  > 1) ? $clog2(NUM_INPUTS)  : 1,
  parameter int NEUR_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input logic clk,
  input logic reset,
  layer_sequencer_if.slave bus
);

  localparam int CNT_MAX =
    (NUM_INPUTS > MEM_LAT) ? NUM_INPUTS : MEM_LAT;
  localparam int CNT_W = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LAST_IN =
    CNT_W'(NUM_INPUTS - 1);
  localparam logic [CNT_W-1:0] LAST_LAT =
    CNT_W'(MEM_LAT - 1);
  localparam logic [NEUR_W-1:0] LAST_N =
    NEUR_W'(NUM_NEURONS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_BIAS,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [NEUR_W-1:0] neuron, neuron_nx;
  logic [MEM_LAT-1:0] pipe_v;
  logic              push_v;
`ifdef LAYER_SEQ_BIAS_EN
  logic [MEM_LAT-1:0] pipe_b;
  logic              push_b;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      neuron <= '0;
      pipe_v <= '0;
`ifdef LAYER_SEQ_BIAS_EN
      pipe_b <= '0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      neuron <= neuron_nx;
      pipe_v <= MEM_LAT'({pipe_v, push_v});
`ifdef LAYER_SEQ_BIAS_EN
      pipe_b <= MEM_LAT'({pipe_b, push_b});
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    neuron_nx    = neuron;
    push_v       = 1'b0;
`ifdef LAYER_SEQ_BIAS_EN
    push_b       = 1'b0;
`endif
    bus.done     = 1'b0;
    bus.AG_rst   = 1'b0;
    bus.AG_read  = 1'b0;
    bus.ALU_rst  = 1'b0;
    bus.in_idx   = '0;
    bus.out_we   = 1'b0;
    unique case (state)
      S_IDLE: begin
        neuron_nx = '0;
        cnt_nx    = '0;
        if (bus.start) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        bus.AG_rst  = 1'b1;
        bus.ALU_rst = 1'b1;
        cnt_nx      = '0;
        state_nx    = S_ISSUE;
      end
      S_ISSUE: begin
        bus.AG_read = 1'b1;
        bus.in_idx  = IN_W'(cnt);
        push_v      = 1'b1;
        if (cnt == LAST_IN) begin
          cnt_nx = '0;
`ifdef LAYER_SEQ_BIAS_EN
          state_nx = S_BIAS;
`else
          state_nx = S_DRAIN;
`endif
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
`ifdef LAYER_SEQ_BIAS_EN
      S_BIAS: begin
        push_v   = 1'b1;
        push_b   = 1'b1;
        state_nx = S_DRAIN;
      end
`endif
      // Hold off the write until the last term has left the delay pipe
      S_DRAIN: begin
        if (cnt == LAST_LAT) begin
          cnt_nx   = '0;
          state_nx = S_WRITE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_WRITE: begin
        bus.out_we = 1'b1;
        if (neuron == LAST_N) begin
          state_nx = S_DONE;
        end else begin
          neuron_nx = neuron + 1'b1;
          state_nx  = S_CLEAR;
        end
      end
      S_DONE: begin
        bus.done  = 1'b1;
        neuron_nx = '0;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.out_addr = neuron;
  assign bus.ALU_en   = pipe_v[MEM_LAT-1];
`ifdef LAYER_SEQ_BIAS_EN
  assign bus.bias_sel = pipe_b[MEM_LAT-1];
`else
  assign bus.bias_sel = 1'b0;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized check of layer_sequencer against a per-cycle timeline model.
// Two instances: default geometry, and NUM_INPUTS=1/NUM_NEURONS=1/MEM_LAT=3.
module tb_layer_sequencer;

`ifdef LAYER_SEQ_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  localparam int NI_A = 4, NN_A = 3, ML_A = 1;
  localparam int NI_B = 1, NN_B = 1, ML_B = 3;
  localparam int P_A = NI_A + ML_A + 2 + B;
  localparam int P_B = NI_B + ML_B + 2 + B;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  layer_sequencer_if #(.IN_W(2), .NEUR_W(2)) ia ();
  layer_sequencer_if #(.IN_W(1), .NEUR_W(1)) ib ();

  layer_sequencer #(
    .NUM_INPUTS(NI_A), .NUM_NEURONS(NN_A), .MEM_LAT(ML_A)
  ) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));

  layer_sequencer #(
    .NUM_INPUTS(NI_B), .NUM_NEURONS(NN_B), .MEM_LAT(ML_B)
  ) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

  // [15]busy [14]done [13]AG_rst [12]AG_read [11]ALU_rst
  // [10]ALU_en [9]bias_sel [8]out_we [7:4]in_idx [3:0]out_addr
  logic [15:0] obs_a, obs_b;
  assign obs_a = {ia.busy, ia.done, ia.AG_rst, ia.AG_read,
                  ia.ALU_rst, ia.ALU_en, ia.bias_sel, ia.out_we,
                  4'(ia.in_idx), 4'(ia.out_addr)};
  assign obs_b = {ib.busy, ib.done, ib.AG_rst, ib.AG_read,
                  ib.ALU_rst, ib.ALU_en, ib.bias_sel, ib.out_we,
                  4'(ib.in_idx), 4'(ib.out_addr)};

  // j = cycles since the edge that accepted start (0 = first CLEAR cycle)
  function automatic logic [15:0] model(int ni, int nn, int ml, int j);
    int p, ph, n;
    logic [15:0] e;
    p = ni + ml + 2 + B;
    e = '0;
    if (j < 0 || j > nn * p) return e;
    if (j == nn * p) begin
      e[15] = 1'b1;
      e[14] = 1'b1;
      e[3:0] = 4'(nn - 1);
      return e;
    end
    n = j / p;
    ph = j % p;
    e[15] = 1'b1;
    e[3:0] = 4'(n);
    if (ph == 0) begin
      e[13] = 1'b1;
      e[11] = 1'b1;
    end
    if (ph >= 1 && ph <= ni) begin
      e[12] = 1'b1;
      e[7:4] = 4'(ph - 1);
    end
    if (ph - ml >= 1 && ph - ml <= ni + B) e[10] = 1'b1;
    if (B == 1 && ph - ml == ni + 1) e[9] = 1'b1;
    if (ph == p - 1) e[8] = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    ia.start = 1'b0;
    ib.start = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs_a !== 16'h0 || obs_b !== 16'h0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got a=%h b=%h want 0000",
                 i, obs_a, obs_b);
      end
    end
  endtask

  task automatic test_layer_a(int runs);
    logic [15:0] exp;
    for (int r = 0; r < runs; r++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1 ia.start = 1'b1;
      for (int j = 0; j <= NN_A * P_A + 1; j++) begin
        @(posedge clk); #1;
        exp = model(NI_A, NN_A, ML_A, j);
        checks++;
        if (obs_a !== exp) begin
          errors++;
          $display("FAIL layer_a run=%0d j=%0d got %h want %h",
                   r, j, obs_a, exp);
        end
        ia.start = (j < NN_A * P_A + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      ia.start = 1'b0;
    end
  endtask

  task automatic test_start_held();
    logic [15:0] exp;
    int jj;
    int gap;
    gap = NN_A * P_A + 2;
    #1 ia.start = 1'b1;
    for (int j = 0; j < 2 * gap; j++) begin
      @(posedge clk); #1;
      jj = (j < gap) ? j : j - gap;
      exp = model(NI_A, NN_A, ML_A, jj);
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL start_held j=%0d got %h want %h", j, obs_a, exp);
      end
      if (j >= gap) ia.start = 1'b0;
    end
    ia.start = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [15:0] exp;
    int k;
    k = P_A + 1 + int'($urandom_range(0, NI_A - 1));
    #1 ia.start = 1'b1;
    for (int j = 0; j <= k; j++) begin
      @(posedge clk); #1;
      ia.start = 1'b0;
      exp = model(NI_A, NN_A, ML_A, j);
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL abort_pre j=%0d got %h want %h", j, obs_a, exp);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_a !== 16'h0) begin
        errors++;
        $display("FAIL abort_idle cyc=%0d got %h want 0000", i, obs_a);
      end
      @(posedge clk); #1;
    end
    ia.start = 1'b1;
    for (int j = 0; j <= NN_A * P_A + 1; j++) begin
      @(posedge clk); #1;
      ia.start = 1'b0;
      exp = model(NI_A, NN_A, ML_A, j);
      checks++;
      if (obs_a !== exp) begin
        errors++;
        $display("FAIL abort_rerun j=%0d got %h want %h", j, obs_a, exp);
      end
    end
  endtask

  task automatic test_small_cfg(int runs);
    logic [15:0] exp;
    for (int r = 0; r < runs; r++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 ib.start = 1'b1;
      for (int j = 0; j <= NN_B * P_B + 1; j++) begin
        @(posedge clk); #1;
        exp = model(NI_B, NN_B, ML_B, j);
        checks++;
        if (obs_b !== exp) begin
          errors++;
          $display("FAIL small_cfg run=%0d j=%0d got %h want %h",
                   r, j, obs_b, exp);
        end
        ib.start = (j < NN_B * P_B + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      ib.start = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_layer_a(3);
    test_start_held();
    test_reset_abort();
    test_small_cfg(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
